// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, parity
// types and the oversampling ratios the receiver supports.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESC_W        = 6;

  localparam logic [PRESC_W-1:0] PRESC_8  = 6'd8;
  localparam logic [PRESC_W-1:0] PRESC_16 = 6'd16;
  localparam logic [PRESC_W-1:0] PRESC_32 = 6'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/rx_edge_bit_counter.sv
// Oversampling edge counter and data-bit counter for the UART receiver.
// Flags the three majority-vote sample points and the end of each bit.
module rx_edge_bit_counter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               enable,
  input  logic               clear,
  input  logic               restart,
  input  logic               bit_en,
  output logic               sample_pt,
  output logic               bit_end,
  output logic               last_bit
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [PRESC_W-1:0] edge_cnt;
  logic [PRESC_W-1:0] half;
  logic [BCW-1:0]     bit_cnt;

  assign half      = prescale >> 1;
  assign sample_pt = (edge_cnt == half - 6'd1) || (edge_cnt == half) ||
                     (edge_cnt == half + 6'd1);
  assign bit_end   = (edge_cnt == prescale - 6'd1);
  assign last_bit  = (bit_cnt == BCW'(DATA_WIDTH - 1));

  // restart: the current cycle already counts as edge 0 of a new start bit
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (restart) begin
      edge_cnt <= 6'd1;
      bit_cnt  <= '0;
    end else if (enable) begin
      if (bit_end) begin
        edge_cnt <= '0;
        if (bit_en) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: oversampled, majority-voted, LSB-first deserializer with
// optional parity and stop-bit checking; registered one-cycle strobes.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  rx_state_e state, state_nxt;

  logic                  cnt_en, cnt_clr, cnt_restart;
  logic                  sample_pt, bit_end, last_bit;
  logic [2:0]            samp;
  logic                  bit_val;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_q, par_typ_q, frame_bad;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  assign bit_val = maj3(samp);

  rx_edge_bit_counter #(.DATA_WIDTH(DATA_WIDTH)) u_cnt (
    .CLK       (CLK),
    .RST       (RST),
    .prescale  (PRESCALE),
    .enable    (cnt_en),
    .clear     (cnt_clr),
    .restart   (cnt_restart),
    .bit_en    (state == DATA),
    .sample_pt (sample_pt),
    .bit_end   (bit_end),
    .last_bit  (last_bit)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_restart = 1'b0;
    cnt_clr     = (state == IDLE) && RX_IN;
    cnt_en      = (state != IDLE) || !RX_IN;
    case (state)
      IDLE:    if (!RX_IN) state_nxt = START;
      START:   if (bit_end) state_nxt = bit_val ? IDLE : DATA;
      DATA:    if (bit_end && last_bit) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP: begin
        if (bit_end) begin
          if (!RX_IN) begin
            state_nxt   = START;
            cnt_restart = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit decisions: sample capture, shifting, checks and strobes
  always_ff @(posedge CLK) begin
    if (RST) begin
      samp       <= '0;
      shreg      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      frame_bad  <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (sample_pt) samp <= {samp[1:0], RX_IN};
      if (bit_end) begin
        case (state)
          START: begin
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            frame_bad <= 1'b0;
          end
          DATA: shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
          PARITY: begin
            if (bit_val != (^shreg ^ (par_typ_q == PAR_ODD))) begin
              PAR_ERR   <= 1'b1;
              frame_bad <= 1'b1;
            end
          end
          STOP: begin
            if (!bit_val) begin
              STP_ERR <= 1'b1;
            end else if (!frame_bad) begin
              DATA_VALID <= 1'b1;
              P_DATA     <= shreg;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: frames are driven serially, expected
// strobes (kind, data, cycle) are queued and matched as the DUT emits them.
module tb_uart_rx_fsm;
  import uart_pkg::*;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         RX_IN = 1'b1;
  logic [5:0]   PRESCALE = 6'd8;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID, PAR_ERR, STP_ERR;

  typedef struct {
    int           kind;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [W-1:0] last_good = '0;

  uart_rx_fsm #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // kind: 0 = DATA_VALID, 1 = PAR_ERR, 2 = STP_ERR
  always @(negedge CLK) begin
    if (DATA_VALID || PAR_ERR || STP_ERR) begin
      int   k;
      exp_t e;
      chk("exclusive", 32'((DATA_VALID && (PAR_ERR || STP_ERR)) || (PAR_ERR && STP_ERR)), 32'd0);
      k = DATA_VALID ? 0 : (PAR_ERR ? 1 : 2);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", k, e.kind);
        chk("strobe_cycle", cyc, e.cyc);
        chk(k == 0 ? "p_data" : "p_data_held", 32'(P_DATA), 32'(e.data));
      end
    end
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input int p, input logic pen,
                            input logic ptyp, input logic bad_par, input logic stop_bit,
                            input logic flip, input int abort_at);
    logic [W+2:0] bits;
    int nb;
    int t0;
    PRESCALE = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    nb   = W + 2 + (pen ? 1 : 0);
    bits = '0;
    for (int i = 0; i < W; i++) bits[1+i] = d[i];
    if (pen) bits[W+1] = (^d) ^ ptyp ^ bad_par;
    bits[nb-1] = stop_bit;
    t0 = cyc;
    if (abort_at < 0) begin
      if (pen && bad_par) sb.push_back('{1, last_good, t0 + (W + 2) * p});
      if (!stop_bit) begin
        sb.push_back('{2, last_good, t0 + nb * p});
      end else if (!(pen && bad_par)) begin
        sb.push_back('{0, d, t0 + nb * p});
        last_good = d;
      end
    end
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < p; j++) begin
        if (b * p + j == abort_at) begin
          RST   = 1'b1;
          RX_IN = 1'b1;
          @(posedge CLK);
          #1;
          chk("abort_p_data", 32'(P_DATA), 32'd0);
          chk("abort_data_valid", 32'(DATA_VALID), 32'd0);
          chk("abort_par_err", 32'(PAR_ERR), 32'd0);
          chk("abort_stp_err", 32'(STP_ERR), 32'd0);
          last_good = '0;
          RST = 1'b0;
          return;
        end
        RX_IN = (flip && j == p / 2) ? ~bits[b] : bits[b];
        @(posedge CLK);
        #1;
      end
    end
    RX_IN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_p_data", 32'(P_DATA), 32'd0);
    chk("reset_data_valid", 32'(DATA_VALID), 32'd0);
    chk("reset_par_err", 32'(PAR_ERR), 32'd0);
    chk("reset_stp_err", 32'(STP_ERR), 32'd0);
    RST = 1'b0;
    idle(2);

    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    idle(4);
    send_frame(8'h3C, 16, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b0, -1);
    idle(4);
    send_frame(8'h3C, 16, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b0, -1);
    idle(4);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(24);
    chk("idle_after_stp_err", 32'(dut.state), 32'(IDLE));

    RX_IN = 1'b0;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    repeat (6) begin
      @(posedge CLK);
      #1;
    end
    chk("glitch_idle", 32'(dut.state), 32'(IDLE));
    idle(2);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    idle(4);

    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    send_frame(8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 40);
    idle(4);
    send_frame(8'h5A, 32, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b0, -1);
    idle(64);

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
